lc3_mem_ctrl: RTL and testbench

LC-3 memory-interface controller: owns MAR and MDR and drives the single-port main-memory block's we/re/address/data pins on behalf of the datapath. It runs the memory's ready_bit handshake, including the drain of its delayed ready pulse. It returns read data to MDR with a one-cycle completion strobe (R) toward the control FSM. It sits between the datapath bus and main memory.

---
 rtl/lc3_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// lc3_mem_ctrl: owns MAR/MDR and runs the main-memory re/we + ready_bit handshake.
// Rev 1.0
module lc3_mem_ctrl #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_bus_in,
  input  logic              i_ld_mar,
  input  logic              i_ld_mdr,
  input  logic              i_mio_en,
  input  logic              i_r_w,
  output logic [ADDR_W-1:0] o_mar_q,
  output logic [DATA_W-1:0] o_mdr_q,
  output logic              o_mem_r,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_raddr,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [DATA_W-1:0] o_mem_d,
  input  logic [DATA_W-1:0] i_mem_dout,
  input  logic              i_mem_ready
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0]   c_TIMEOUT = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W:0]    w_cnt_inc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_mem_r;
  logic              r_err;
  logic              w_launch;
  logic              w_done;
  logic              w_timeout;

  // Abort on the edge where the busy-cycle count reaches TIMEOUT.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_timeout = (r_state != ST_IDLE) && (w_cnt_inc == c_TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_mio_en) begin
          w_launch    = 1'b1;
          w_state_nxt = i_r_w ? ST_WR : ST_RD;
        end
      end
      ST_RD, ST_WR: begin
        if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else if (i_mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Wait out the memory's lingering ready so it cannot finish the next access.
        if (w_timeout || !i_mem_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_mem_r <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mem_r <= w_done;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_launch) begin
        r_cnt <= '0;
      end else if ((r_state != ST_IDLE) && ({1'b0, r_cnt} != c_TIMEOUT)) begin
        r_cnt <= w_cnt_inc[CNT_W-1:0];
      end
      if ((r_state == ST_IDLE) && i_ld_mar) begin
        r_mar <= i_bus_in[ADDR_W-1:0];
      end
      if ((r_state == ST_IDLE) && i_ld_mdr) begin
        r_mdr <= i_bus_in;
      end else if ((r_state == ST_RD) && w_done) begin
        r_mdr <= i_mem_dout;
      end
    end
  end

  assign o_mar_q     = r_mar;
  assign o_mdr_q     = r_mdr;
  assign o_mem_r     = r_mem_r;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_err       = r_err;
  assign o_mem_re    = (r_state == ST_RD);
  assign o_mem_we    = (r_state == ST_WR);
  assign o_mem_raddr = r_mar;
  assign o_mem_waddr = r_mar;
  assign o_mem_d     = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
`default_nettype none
// tb_lc3_mem_ctrl: vector table plus scoreboard bench for lc3_mem_ctrl.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_bus_in = 16'h0000;
  logic        i_ld_mar = 1'b0;
  logic        i_ld_mdr = 1'b0;
  logic        i_mio_en = 1'b0;
  logic        i_r_w = 1'b0;
  logic [6:0]  o_mar_q;
  logic [15:0] o_mdr_q;
  logic        o_mem_r;
  logic        o_busy;
  logic        o_err;
  logic        o_mem_we;
  logic        o_mem_re;
  logic [6:0]  o_mem_raddr;
  logic [6:0]  o_mem_waddr;
  logic [15:0] o_mem_d;
  logic [15:0] i_mem_dout = 16'h0000;
  logic        i_mem_ready = 1'b0;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.ADDR_W(7), .DATA_W(16), .TIMEOUT(15)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_bus_in    (i_bus_in),
    .i_ld_mar    (i_ld_mar),
    .i_ld_mdr    (i_ld_mdr),
    .i_mio_en    (i_mio_en),
    .i_r_w       (i_r_w),
    .o_mar_q     (o_mar_q),
    .o_mdr_q     (o_mdr_q),
    .o_mem_r     (o_mem_r),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_mem_we    (o_mem_we),
    .o_mem_re    (o_mem_re),
    .o_mem_raddr (o_mem_raddr),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_d     (o_mem_d),
    .i_mem_dout  (i_mem_dout),
    .i_mem_ready (i_mem_ready)
  );

  // Main-memory model: write ready 1 edge after we; read data 1 edge, ready 2 edges after re.
  logic [15:0] mem [128];
  logic        no_ready = 1'b0;
  logic        re_d = 1'b0;
  always @(posedge clk) begin
    re_d <= o_mem_re;
    if (o_mem_we) mem[o_mem_waddr] <= o_mem_d;
    if (o_mem_re) i_mem_dout <= mem[o_mem_raddr];
    i_mem_ready <= !no_ready && (o_mem_we || (o_mem_re && re_d));
  end

  typedef struct {
    logic        rw;
    logic [6:0]  a;
    logic [15:0] d;
  } sb_t;

  typedef struct {
    logic        rw;
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
    int          exp_re;
    int          exp_we;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   rpulses = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer plus handshake invariants, sampled on the falling edge.
  initial begin
    logic prev_r;
    sb_t  e;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (o_mem_re && o_mem_we) begin
        bad++;
        $display("FAIL re_we_both: re=%b we=%b required never both 1", o_mem_re, o_mem_we);
      end
      if (o_mem_r) begin
        rpulses++;
        if (prev_r) begin
          bad++;
          $display("FAIL mem_r_consecutive: mem_r=1 in two cycles, required single pulse");
        end
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_mem_r: mem_r=1 with no access pending, required 0");
        end else begin
          e = sb_q.pop_front();
          if (e.rw) check("sb_write_data", mem[e.a], e.d);
          else      check("sb_read_mdr", o_mdr_q, e.d);
        end
      end
      prev_r = o_mem_r;
    end
  end

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40 && o_busy; i++) tick();
    check(nm, 16'(o_busy), 16'd0);
  endtask

  task automatic run_vec(input vec_t v, output int re_c, output int we_c,
                         output int pulses, output int pin_bad);
    int p0;
    i_bus_in = v.rw ? v.d : 16'h0000;
    i_ld_mdr = 1'b1;
    tick();
    i_ld_mdr = 1'b0;
    i_bus_in = {9'd0, v.a};
    i_ld_mar = 1'b1;
    i_mio_en = 1'b1;
    i_r_w    = v.rw;
    sb_q.push_back('{v.rw, v.a, v.exp});
    p0 = rpulses;
    tick();
    i_ld_mar = 1'b0;
    i_mio_en = 1'b0;
    i_bus_in = 16'hFFFF;
    re_c = 0;
    we_c = 0;
    pin_bad = 0;
    for (int i = 0; i < 40 && o_busy; i++) begin
      if (o_mem_re) begin
        re_c++;
        if (o_mem_raddr != v.a) pin_bad++;
      end
      if (o_mem_we) begin
        we_c++;
        if (o_mem_waddr != v.a || o_mem_d != v.d) pin_bad++;
      end
      tick();
    end
    check("vec_idle", 16'(o_busy), 16'd0);
    pulses = rpulses - p0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int re_c, we_c, pulses, pin_bad, p0, n, re_tot;
    logic [6:0] a;
    logic err_pre;

    vecs[0] = '{1'b1, 7'h05, 16'hBEEF, 16'hBEEF, 0, 2};
    vecs[1] = '{1'b0, 7'h05, 16'h0000, 16'hBEEF, 3, 0};
    vecs[2] = '{1'b1, 7'h01, 16'h1111, 16'h1111, 0, 2};
    vecs[3] = '{1'b1, 7'h7F, 16'h2222, 16'h2222, 0, 2};
    vecs[4] = '{1'b1, 7'h42, 16'h4242, 16'h4242, 0, 2};
    vecs[5] = '{1'b0, 7'h42, 16'h0000, 16'h4242, 3, 0};
    vecs[6] = '{1'b1, 7'h00, 16'hFFFF, 16'hFFFF, 0, 2};
    vecs[7] = '{1'b0, 7'h00, 16'h0000, 16'hFFFF, 3, 0};

    tick();
    tick();
    check("reset_ctl", {4'd0, o_mar_q, o_mem_r, o_busy, o_err, o_mem_we, o_mem_re}, 16'd0);
    check("reset_mdr", o_mdr_q, 16'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], re_c, we_c, pulses, pin_bad);
      check($sformatf("vec%0d_re_cycles", k), 16'(re_c), 16'(vecs[k].exp_re));
      check($sformatf("vec%0d_we_cycles", k), 16'(we_c), 16'(vecs[k].exp_we));
      check($sformatf("vec%0d_mem_r_count", k), 16'(pulses), 16'd1);
      check($sformatf("vec%0d_pins", k), 16'(pin_bad), 16'd0);
      check($sformatf("vec%0d_mdr", k), o_mdr_q, vecs[k].exp);
    end

    // Back-to-back reads with mio_en held high throughout.
    p0 = rpulses;
    re_tot = 0;
    i_r_w = 1'b0;
    i_mio_en = 1'b1;
    i_ld_mar = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = (k % 2 == 1) ? 7'h7F : 7'h01;
      i_bus_in = {9'd0, a};
      sb_q.push_back('{1'b0, a, (k % 2 == 1) ? 16'h2222 : 16'h1111});
      n = 0;
      while (!o_mem_r && n < 50) begin
        tick();
        if (o_mem_re) re_tot++;
        n++;
      end
      check($sformatf("b2b%0d_complete", k), 16'(o_mem_r), 16'd1);
      if (k == 3) begin
        i_mio_en = 1'b0;
        i_ld_mar = 1'b0;
      end
      tick();
    end
    wait_idle("b2b_idle");
    check("b2b_mem_r_count", 16'(rpulses - p0), 16'd4);
    check("b2b_re_cycles", 16'(re_tot), 16'd12);
    check("b2b_sb_empty", 16'(sb_q.size()), 16'd0);

    // Loads and mio_en ignored while busy.
    i_bus_in = 16'h5555;
    i_ld_mdr = 1'b1;
    tick();
    i_ld_mdr = 1'b0;
    i_bus_in = 16'h0001;
    i_ld_mar = 1'b1;
    i_mio_en = 1'b1;
    i_r_w = 1'b0;
    sb_q.push_back('{1'b0, 7'h01, 16'h1111});
    p0 = rpulses;
    tick();
    i_mio_en = 1'b0;
    i_bus_in = 16'h0033;
    tick();
    i_ld_mar = 1'b0;
    i_bus_in = 16'hAAAA;
    i_ld_mdr = 1'b1;
    tick();
    i_ld_mdr = 1'b0;
    check("blk_mar_during_rd", 16'(o_mar_q), 16'h0001);
    check("blk_mdr_during_rd", o_mdr_q, 16'h5555);
    n = 0;
    while (!o_mem_r && n < 40) begin
      tick();
      n++;
    end
    check("blk_complete", 16'(o_mem_r), 16'd1);
    check("blk_mdr_read", o_mdr_q, 16'h1111);
    i_mio_en = 1'b1;
    tick();
    i_mio_en = 1'b0;
    wait_idle("blk_idle");
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_busy) n++;
    end
    check("blk_no_relaunch", 16'(n), 16'd0);
    check("blk_mem_r_count", 16'(rpulses - p0), 16'd1);
    check("blk_mar_final", 16'(o_mar_q), 16'h0001);

    // Asynchronous reset in the middle of a read.
    i_bus_in = 16'h7777;
    i_ld_mdr = 1'b1;
    tick();
    i_ld_mdr = 1'b0;
    i_bus_in = 16'h0005;
    i_ld_mar = 1'b1;
    i_mio_en = 1'b1;
    i_r_w = 1'b0;
    tick();
    i_ld_mar = 1'b0;
    i_mio_en = 1'b0;
    tick();
    check("rst_pre_re", 16'(o_mem_re), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_re", 16'(o_mem_re), 16'd0);
    check("rst_async_ctl", {4'd0, o_mar_q, o_mem_r, o_busy, o_err, o_mem_we, o_mem_re}, 16'd0);
    check("rst_async_mdr", o_mdr_q, 16'd0);
    p0 = rpulses;
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_mem_re || o_mem_we || o_busy) n++;
    end
    check("rst_no_stray", 16'(n), 16'd0);
    check("rst_no_mem_r", 16'(rpulses - p0), 16'd0);

    // Timeout: memory never raises ready.
    no_ready = 1'b1;
    i_bus_in = 16'h5A5A;
    i_ld_mdr = 1'b1;
    tick();
    i_ld_mdr = 1'b0;
    i_bus_in = 16'h0005;
    i_ld_mar = 1'b1;
    i_mio_en = 1'b1;
    i_r_w = 1'b0;
    p0 = rpulses;
    tick();
    i_ld_mar = 1'b0;
    i_mio_en = 1'b0;
    n = 0;
    err_pre = 1'b0;
    while (o_busy && n < 40) begin
      err_pre = o_err;
      tick();
      n++;
    end
    check("to_cycles", 16'(n), 16'd15);
    check("to_err_before", 16'(err_pre), 16'd0);
    check("to_err", 16'(o_err), 16'd1);
    check("to_re_low", 16'(o_mem_re), 16'd0);
    check("to_mdr_kept", o_mdr_q, 16'h5A5A);
    tick();
    check("to_no_mem_r", 16'(rpulses - p0), 16'd0);
    no_ready = 1'b0;
    tick();

    run_vec('{1'b1, 7'h10, 16'h1234, 16'h1234, 0, 2}, re_c, we_c, pulses, pin_bad);
    check("post_to_wr_mem_r", 16'(pulses), 16'd1);
    run_vec('{1'b0, 7'h10, 16'h0000, 16'h1234, 3, 0}, re_c, we_c, pulses, pin_bad);
    check("post_to_rd_mem_r", 16'(pulses), 16'd1);
    check("post_to_rd_mdr", o_mdr_q, 16'h1234);
    check("post_to_err_sticky", 16'(o_err), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("err_cleared_by_rst", 16'(o_err), 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("final_sb_empty", 16'(sb_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
